// File: rtl/ws2812_pkg.sv
// rtl/ws2812_pkg.sv - shared types, widths and pixel scaling helper for the WS2812 frame sequencer
package ws2812_pkg;

    localparam int PIXEL_W         = 24;
    localparam int CHANNEL_W       = 8;
    localparam int MIN_SLOT_CYCLES = 75;

    // Explicit encodings keep the state register layout stable across tools
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SEND  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_LATCH = 3'd4
    } state_e;

    // A single-entry chain still needs a one-bit address
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Per channel: (c * (b + 1)) >> 8, so b = 255 is identity and b = 0 blanks
    function automatic logic [PIXEL_W-1:0] scale_pixel(input logic [PIXEL_W-1:0] px,
                                                       input logic [CHANNEL_W-1:0] b);
        logic [PIXEL_W-1:0] res;
        logic [15:0]        prod;
        res = '0;
        for (int ch = 0; ch < 3; ch++) begin
            prod = 16'(px[ch*CHANNEL_W +: CHANNEL_W]) * (16'(b) + 16'd1);
            res[ch*CHANNEL_W +: CHANNEL_W] = prod[15:8];
        end
        return res;
    endfunction

endpackage

// File: rtl/ws2812_frame_sequencer_if.sv
// rtl/ws2812_frame_sequencer_if.sv - pixel write, start and serializer-facing signals (brightness under WS2812_BRIGHTNESS_EN)
interface ws2812_frame_sequencer_if #(
    parameter int NUM_LEDS = 8
);
    import ws2812_pkg::*;

    localparam int AW = addr_width(NUM_LEDS);

    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [PIXEL_W-1:0]   wr_data;
    logic                 start;
`ifdef WS2812_BRIGHTNESS_EN
    logic [CHANNEL_W-1:0] brightness;
`endif
    logic [PIXEL_W-1:0]   value;
    logic                 trigger;
    logic                 busy;
    logic                 done;

    modport master (
`ifdef WS2812_BRIGHTNESS_EN
        output brightness,
`endif
        output wr_en, wr_addr, wr_data, start,
        input  value, trigger, busy, done
    );

    modport slave (
`ifdef WS2812_BRIGHTNESS_EN
        input  brightness,
`endif
        input  wr_en, wr_addr, wr_data, start,
        output value, trigger, busy, done
    );

endinterface

// File: rtl/ws2812_pixel_ram.sv
// rtl/ws2812_pixel_ram.sv - pixel buffer with one synchronous write port and one synchronous read port
module ws2812_pixel_ram #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int W     = 24
) (
    input  logic          clock,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_q;

    // Write and read on the same edge: a read of the address being written returns the old word
    always_ff @(posedge clock) begin
        if (we_i && (int'(waddr_i) < DEPTH)) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ws2812_frame_sequencer.sv
// rtl/ws2812_frame_sequencer.sv - steps a pixel buffer into the WS2812 serializer, then holds the latch gap; optional WS2812_BRIGHTNESS_EN
module ws2812_frame_sequencer
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS     = 8,
    parameter int SLOT_CYCLES  = 80,
    parameter int LATCH_CYCLES = 750
) (
    input  logic                    clock,
    input  logic                    reset,
    ws2812_frame_sequencer_if.slave bus
);

    localparam int AW      = addr_width(NUM_LEDS);
    localparam int CNT_MAX = (SLOT_CYCLES > LATCH_CYCLES) ? SLOT_CYCLES : LATCH_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    if (SLOT_CYCLES < MIN_SLOT_CYCLES) begin : g_bad_slot
        $error("SLOT_CYCLES too short for one serializer transmission");
    end
    if (NUM_LEDS < 1) begin : g_bad_leds
        $error("NUM_LEDS must be at least 1");
    end
    if (LATCH_CYCLES < 1) begin : g_bad_latch
        $error("LATCH_CYCLES must be at least 1");
    end

    state_e               state_q, state_d;
    logic [AW-1:0]        idx_q, idx_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [PIXEL_W-1:0]   value_q, value_d;
    logic                 trigger_q, trigger_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [PIXEL_W-1:0]   rdata;
    logic [PIXEL_W-1:0]   pixel_out;

    ws2812_pixel_ram #(
        .DEPTH (NUM_LEDS),
        .AW    (AW),
        .W     (PIXEL_W)
    ) u_ram (
        .clock   (clock),
        .we_i    (bus.wr_en),
        .waddr_i (bus.wr_addr),
        .wdata_i (bus.wr_data),
        .re_i    (state_q == ST_FETCH),
        .raddr_i (idx_q),
        .rdata_o (rdata)
    );

`ifdef WS2812_BRIGHTNESS_EN
    logic [CHANNEL_W-1:0] bright_q, bright_d;

    // Brightness is captured at the start edge so a frame is scaled uniformly
    always_comb begin
        bright_d = bright_q;
        if (state_q == ST_IDLE && bus.start) begin
            bright_d = bus.brightness;
        end
    end

    // Scale register for the frame-wide brightness
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bright_q <= '0;
        end else begin
            bright_q <= bright_d;
        end
    end

    assign pixel_out = scale_pixel(rdata, bright_q);
`else
    assign pixel_out = rdata;
`endif

    // Frame sequencing; the last slot's final cycle is folded into the latch count
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        value_d   = value_q;
        busy_d    = busy_q;
        trigger_d = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_FETCH;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_FETCH: begin
                state_d = ST_SEND;
            end
            ST_SEND: begin
                value_d   = pixel_out;
                trigger_d = 1'b1;
                cnt_d     = CW'(SLOT_CYCLES - 2);
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    if (idx_q == AW'(NUM_LEDS - 1)) begin
                        state_d = ST_LATCH;
                        cnt_d   = CW'(LATCH_CYCLES);
                    end else begin
                        state_d = ST_FETCH;
                        idx_d   = idx_q + AW'(1);
                    end
                end
            end
            ST_LATCH: begin
                if (cnt_q == '0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any frame in flight
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            value_q   <= '0;
            trigger_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            value_q   <= value_d;
            trigger_q <= trigger_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.value   = value_q;
    assign bus.trigger = trigger_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule
